mux_channel_scanner: RTL and testbench

MUX_CHANNEL_SCANNER -- requirements
Module: mux_channel_scanner

---
 rtl/mux_channel_scanner.sv | 142 ++++++++++++++
 tb/tb_mux_channel_scanner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_channel_scanner.sv
// Walks a 16:1 mux over its channels, waits for the mux output to settle, then samples each bit.
// Optional build macro SCAN_MASK_EN adds MaskIn so that selected channels can be skipped.
module mux_channel_scanner #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        ClkIn,
    input  logic        ResetIn,
    input  logic        StartIn,
`ifdef SCAN_MASK_EN
    input  logic [15:0] MaskIn,
`endif
    input  logic        MuxOutIn,
    output logic [3:0]  SelectOut,
    output logic        EnableOut,
    output logic        BusyOut,
    output logic        DoneOut,
    output logic [15:0] ScanDataOut
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} stateT;

    localparam bit HasSettle = (SETTLE_CYCLES != 0);
    localparam logic [2:0] SettleLast = HasSettle ? 3'(SETTLE_CYCLES - 1) : 3'd0;

    stateT       stateQ, stateD;
    logic [3:0]  selQ, selD;
    logic [2:0]  cntQ, cntD;
    logic [15:0] shadowQ, shadowD;
    logic [15:0] dataQ, dataD;
    logic [15:0] startMask, scanMask;
    logic [4:0]  firstCh, nextCh;

`ifdef SCAN_MASK_EN
    logic [15:0] maskQ, maskD;
    assign startMask = MaskIn;
    assign scanMask  = maskQ;
`else
    assign startMask = 16'hFFFF;
    assign scanMask  = 16'hFFFF;
`endif

    // Lowest enabled channel at or above 'from'; bit 4 set means none is left.
    function automatic logic [4:0] firstFrom(input logic [15:0] m, input logic [4:0] from);
        logic [4:0] r;
        r = 5'h10;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && (5'(i) >= from)) begin
                r = 5'(i);
            end
        end
        return r;
    endfunction

    assign firstCh = firstFrom(startMask, 5'd0);
    assign nextCh  = firstFrom(scanMask, {1'b0, selQ} + 5'd1);

    always_comb begin
        stateD  = stateQ;
        selD    = selQ;
        cntD    = cntQ;
        shadowD = shadowQ;
        dataD   = dataQ;
`ifdef SCAN_MASK_EN
        maskD   = maskQ;
`endif
        case (stateQ)
            StIdle: begin
                selD = 4'd0;
                cntD = 3'd0;
                if (StartIn) begin
                    shadowD = 16'h0000;
`ifdef SCAN_MASK_EN
                    maskD   = MaskIn;
`endif
                    if (firstCh[4]) begin
                        // Nothing to scan: publish an all-zero result straight away.
                        dataD  = 16'h0000;
                        stateD = StDone;
                    end else begin
                        selD   = firstCh[3:0];
                        stateD = HasSettle ? StSettle : StSample;
                    end
                end
            end
            StSettle: begin
                if (cntQ == SettleLast) begin
                    cntD   = 3'd0;
                    stateD = StSample;
                end else begin
                    cntD = cntQ + 3'd1;
                end
            end
            StSample: begin
                shadowD[selQ] = MuxOutIn;
                if (nextCh[4]) begin
                    // Result becomes visible together with DoneOut.
                    dataD  = shadowD;
                    selD   = 4'd0;
                    stateD = StDone;
                end else begin
                    selD   = nextCh[3:0];
                    stateD = HasSettle ? StSettle : StSample;
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge ClkIn) begin
        if (ResetIn) begin
            stateQ  <= StIdle;
            selQ    <= 4'd0;
            cntQ    <= 3'd0;
            shadowQ <= 16'h0000;
            dataQ   <= 16'h0000;
`ifdef SCAN_MASK_EN
            maskQ   <= 16'h0000;
`endif
        end else begin
            stateQ  <= stateD;
            selQ    <= selD;
            cntQ    <= cntD;
            shadowQ <= shadowD;
            dataQ   <= dataD;
`ifdef SCAN_MASK_EN
            maskQ   <= maskD;
`endif
        end
    end

    assign SelectOut   = selQ;
    assign EnableOut   = (stateQ == StSettle) || (stateQ == StSample);
    assign BusyOut     = (stateQ != StIdle);
    assign DoneOut     = (stateQ == StDone);
    assign ScanDataOut = dataQ;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Scoreboard bench: two scanners (settle 0 and settle 1) share stimulus; a timing/result
// model predicts each scan, and a negedge monitor compares every output against it.
module tb_mux_channel_scanner;

`ifdef SCAN_MASK_EN
    localparam bit MaskOn = 1'b1;
`else
    localparam bit MaskOn = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } expT;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] muxData, mask;
    logic [3:0]  sel0, sel1;
    logic        en0, en1, busy0, busy1, done0, done1, mux0, mux1;
    logic [15:0] scan0, scan1;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          armed = 1'b0;
    bit          rstSeen = 1'b0;
    int          startE[2] = '{-1000, -1000};
    int          durA[2] = '{0, 0};
    int          freeE[2] = '{0, 0};
    logic [15:0] mskA[2];
    logic [15:0] expScan[2] = '{16'h0, 16'h0};
    expT         q[2][$];

    always #5 clk = ~clk;

    // Mux model: output forced low while disabled.
    assign mux0 = en0 ? muxData[sel0] : 1'b0;
    assign mux1 = en1 ? muxData[sel1] : 1'b0;

    mux_channel_scanner #(.SETTLE_CYCLES(0)) u0 (
        .ClkIn(clk), .ResetIn(rst), .StartIn(start),
`ifdef SCAN_MASK_EN
        .MaskIn(mask),
`endif
        .MuxOutIn(mux0), .SelectOut(sel0), .EnableOut(en0), .BusyOut(busy0),
        .DoneOut(done0), .ScanDataOut(scan0)
    );

    mux_channel_scanner #(.SETTLE_CYCLES(1)) u1 (
        .ClkIn(clk), .ResetIn(rst), .StartIn(start),
`ifdef SCAN_MASK_EN
        .MaskIn(mask),
`endif
        .MuxOutIn(mux1), .SelectOut(sel1), .EnableOut(en1), .BusyOut(busy1),
        .DoneOut(done1), .ScanDataOut(scan1)
    );

    task automatic check(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, i, cyc, act, exp);
        end
    endtask

    function automatic int nthSet(input logic [15:0] m, input int k);
        int c = 0;
        for (int b = 0; b < 16; b++) begin
            if (m[b]) begin
                if (c == k) return b;
                c++;
            end
        end
        return 0;
    endfunction

    // Model: a scan of N channels lasts N*(S+1)+1 cycles; the next start is accepted one
    // cycle after that (back in idle).
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rstSeen = rst;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    armed      = 1'b1;
                    startE[i]  = -1000;
                    durA[i]    = 0;
                    freeE[i]   = cyc + 1;
                    expScan[i] = 16'h0;
                    q[i].delete();
                end else if (start && cyc >= freeE[i]) begin
                    expT e;
                    durA[i]   = $countones(mask) * (i + 1) + 1;
                    startE[i] = cyc;
                    mskA[i]   = mask;
                    freeE[i]  = cyc + durA[i] + 1;
                    e.cyc     = cyc + durA[i] - 1;
                    e.data    = muxData & mask;
                    q[i].push_back(e);
                end
            end
        end
    end

    task automatic monitorOne(input int i, input logic [3:0] sel, input logic en,
                              input logic busy, input logic done, input logic [15:0] scan);
        int   off;
        logic expBusy, expEn;
        int   expSel;
        expT  e;
        off     = cyc - startE[i];
        expBusy = (off >= 0) && (off <= durA[i] - 1);
        expEn   = (off >= 0) && (off <= durA[i] - 2);
        expSel  = expEn ? nthSet(mskA[i], off / (i + 1)) : 0;
        if (rstSeen) begin
            check("reset-state", i, {11'h0, sel, en, busy, done, scan}, 32'h0);
        end
        check("busy", i, 32'(busy), 32'(expBusy));
        check("enable", i, 32'(en), 32'(expEn));
        check("select", i, 32'(sel), 32'(expSel));
        if (done) begin
            if (q[i].size() == 0) begin
                check("done-unexpected", i, 32'(done), 32'h0);
            end else begin
                e = q[i].pop_front();
                check("done-cycle", i, 32'(cyc), 32'(e.cyc));
                expScan[i] = e.data;
            end
        end else if (q[i].size() != 0 && cyc > q[i][0].cyc) begin
            e = q[i].pop_front();
            check("done-missing", i, 32'(cyc), 32'(e.cyc));
        end
        check("scan-data", i, 32'(scan), 32'(expScan[i]));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                monitorOne(0, sel0, en0, busy0, done0, scan0);
                monitorOne(1, sel1, en1, busy1, done1, scan1);
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while ((busy0 || busy1 || q[0].size() != 0 || q[1].size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle-timeout", 0, 32'(n), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic runScan(input logic [15:0] data, input logic [15:0] m, input int len);
        @(negedge clk);
        muxData = data;
        mask    = MaskOn ? m : 16'hFFFF;
        start   = 1'b1;
        repeat (len) @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        muxData = 16'h0;
        mask = 16'hFFFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        runScan(16'hA5C3, 16'hFFFF, 1);
        waitIdle();
        runScan(16'h8001, 16'hFFFF, 1);
        waitIdle();
        // StartIn held high: retrigger only after returning to idle.
        runScan(16'h3C5A, 16'hFFFF, 40);
        waitIdle();
        // Reset in cycle 10 of a scan.
        runScan(16'h1234, 16'hFFFF, 1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitIdle();
        if (MaskOn) begin
            runScan(16'hFFFF, 16'h00F0, 1);
            waitIdle();
            runScan(16'hFFFF, 16'h0000, 1);
            waitIdle();
        end

        for (int k = 0; k < 25; k++) begin
            logic [15:0] m;
            m = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            runScan(16'($urandom), m, $urandom_range(1, 3));
            // Mask changes after acceptance must not affect the running scan.
            if (MaskOn) mask = 16'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            waitIdle();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
